// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// reset-cause codes and the common counter-width calculation.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_BTN  = 2'd2;
  localparam logic [1:0] CAUSE_SW   = 2'd3;

  // Wide enough for the largest exact compare value of any counter.
  function automatic int cnt_width(input int nch, input int hold_cycles,
                                   input int stagger, input int debounce);
    int max_v;
    max_v = hold_cycles;
    if (((nch - 1) * stagger + 1) > max_v) max_v = (nch - 1) * stagger + 1;
    else max_v = max_v;
    if (debounce > max_v) max_v = debounce;
    else max_v = max_v;
    if (max_v < 2) return 1;
    else return $clog2(max_v);
  endfunction

endpackage

// File: rtl/reset_seq_sync_debounce.sv
// Multi-stage synchroniser with an optional stable-time debouncer.
// DEBOUNCE = 0 yields the plain synchronised level.
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Synchroniser shift chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_r <= {SYNC_STAGES{1'b0}};
    else          sync_r <= {sync_r[SYNC_STAGES-2:0], din};
  end

  generate
    if (DEBOUNCE == 0) begin : g_nodeb
      assign dout = sync_r[SYNC_STAGES-1];
    end else begin : g_deb
      localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
      localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
      logic [DW-1:0] cnt_r;
      logic          deb_r;

      // Flip the debounced level only after DEBOUNCE consecutive differing cycles
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_r <= {DW{1'b0}};
          deb_r <= 1'b0;
        end else if (sync_r[SYNC_STAGES-1] == deb_r) begin
          cnt_r <= {DW{1'b0}};
        end else if (cnt_r == DEB_LAST) begin
          cnt_r <= {DW{1'b0}};
          deb_r <= sync_r[SYNC_STAGES-1];
        end else begin
          cnt_r <= cnt_r + DW'(1);
        end
      end

      assign dout = deb_r;
    end
  endgenerate

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: waits for PLL lock, holds reset, releases channels in a
// staggered order and re-enters reset on lock loss, button or software request.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int HOLD_CYCLES = 255,
  parameter int STAGGER     = 16,
  parameter int DEBOUNCE    = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pll_locked,
  input  logic           btn,
  input  logic           sw_rst_req,
  output logic [NCH-1:0] rst_out,
  output logic           ready,
  output logic [1:0]     cause
);

  localparam int CW = cnt_width(NCH, HOLD_CYCLES, STAGGER, DEBOUNCE);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'((NCH - 1) * STAGGER);

  state_e         state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic           lock_s, btn_s, btn_prev_r, btn_rise_s;
  logic           lock_chk_s, trig_chk_s, trig_s;
  logic [1:0]     trig_cause_s;
  logic [NCH-1:0] rst_out_r, rst_out_nxt_s;
  logic           ready_r, ready_nxt_s;
  logic [1:0]     cause_r, cause_nxt_s;

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(0)) u_lock_sync (
    .clk(clk), .reset_n(reset_n), .din(pll_locked), .dout(lock_s)
  );

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_btn_sync (
    .clk(clk), .reset_n(reset_n), .din(btn), .dout(btn_s)
  );

  assign btn_rise_s = btn_s & ~btn_prev_r;

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_ASSERT;
      cnt_r      <= CNT_ZERO;
      btn_prev_r <= 1'b0;
      rst_out_r  <= {NCH{1'b1}};
      ready_r    <= 1'b0;
      cause_r    <= CAUSE_POR;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      btn_prev_r <= btn_s;
      rst_out_r  <= rst_out_nxt_s;
      ready_r    <= ready_nxt_s;
      cause_r    <= cause_nxt_s;
    end
  end

  // Trigger arbitration (lock loss > button > software) and next state
  always_comb begin
    lock_chk_s = 1'b0;
    trig_chk_s = 1'b0;
    case (state_r)
      ST_WAIT_LOCK: trig_chk_s = 1'b1;
      ST_HOLD, ST_RELEASE, ST_RUN: begin
        lock_chk_s = 1'b1;
        trig_chk_s = 1'b1;
      end
      default: begin
        lock_chk_s = 1'b0;
        trig_chk_s = 1'b0;
      end
    endcase

    if (lock_chk_s && !lock_s) begin
      trig_s       = 1'b1;
      trig_cause_s = CAUSE_LOCK;
    end else if (trig_chk_s && btn_rise_s) begin
      trig_s       = 1'b1;
      trig_cause_s = CAUSE_BTN;
    end else if (trig_chk_s && sw_rst_req) begin
      trig_s       = 1'b1;
      trig_cause_s = CAUSE_SW;
    end else begin
      trig_s       = 1'b0;
      trig_cause_s = cause_r;
    end

    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (trig_s) begin
      state_nxt_s = ST_ASSERT;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_ASSERT: begin
          cnt_nxt_s = CNT_ZERO;
          if (btn_s) state_nxt_s = ST_ASSERT;
          else       state_nxt_s = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          cnt_nxt_s = CNT_ZERO;
          if (lock_s) state_nxt_s = ST_HOLD;
          else        state_nxt_s = ST_WAIT_LOCK;
        end
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            state_nxt_s = ST_RELEASE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = ST_HOLD;
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (cnt_r == REL_LAST) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = ST_RELEASE;
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end
        default: begin
          state_nxt_s = ST_ASSERT;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output values for the coming state; channel i drops when the count reaches i*STAGGER
  always_comb begin
    rst_out_nxt_s = rst_out_r;
    ready_nxt_s   = 1'b0;
    case (state_nxt_s)
      ST_RELEASE: begin
        for (int i = 0; i < NCH; i++) begin
          if (cnt_nxt_s == CW'(i * STAGGER)) rst_out_nxt_s[i] = 1'b0;
          else                               rst_out_nxt_s[i] = rst_out_r[i];
        end
      end
      ST_RUN: begin
        rst_out_nxt_s = {NCH{1'b0}};
        ready_nxt_s   = 1'b1;
      end
      default: begin
        rst_out_nxt_s = {NCH{1'b1}};
        ready_nxt_s   = 1'b0;
      end
    endcase

    if (trig_s) cause_nxt_s = trig_cause_s;
    else        cause_nxt_s = cause_r;
  end

  assign rst_out = rst_out_r;
  assign ready   = ready_r;
  assign cause   = cause_r;

endmodule

// File: tb/tb_reset_seq.sv
// Directed plus randomized bench for reset_seq, checked against a timeline
// model that derives channel release times arithmetically from the HOLD start.
module tb_reset_seq;

  localparam int NCH  = 3;
  localparam int HOLD = 8;
  localparam int STAG = 4;
  localparam int DEB  = 16;
  localparam int SYNC = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           pll_locked = 1'b1;
  logic           btn = 1'b0;
  logic           sw_rst_req = 1'b0;
  logic [NCH-1:0] rst_out;
  logic           ready;
  logic [1:0]     cause;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reset_seq #(
    .NCH(NCH), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .DEBOUNCE(DEB), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .btn(btn),
    .sw_rst_req(sw_rst_req), .rst_out(rst_out), .ready(ready), .cause(cause)
  );

  // Model: mode 0 = held in reset, 1 = waiting for lock, 2 = sequencing from m_thold
  int         m_mode, m_n, m_thold, m_run;
  logic [1:0] m_cause;
  bit         m_deb, m_rose;
  bit         lq[$];
  bit         bq[$];

  function automatic void model_reset();
    m_mode = 0; m_n = 0; m_thold = -1; m_run = 0;
    m_cause = 2'd0; m_deb = 1'b0; m_rose = 1'b0;
    lq.delete(); bq.delete();
    for (int i = 0; i < SYNC; i++) begin
      lq.push_back(1'b0);
      bq.push_back(1'b0);
    end
  endfunction

  function automatic void model_step();
    bit lock_pre, bsync_pre, deb_pre, rose_pre, hit;
    logic [1:0] c;
    m_n++;
    lock_pre = lq[0]; bsync_pre = bq[0]; deb_pre = m_deb; rose_pre = m_rose;
    hit = 1'b0; c = m_cause;
    if (m_mode == 2 && !lock_pre) begin hit = 1'b1; c = 2'd1; end
    else if (m_mode != 0 && rose_pre) begin hit = 1'b1; c = 2'd2; end
    else if (m_mode != 0 && sw_rst_req) begin hit = 1'b1; c = 2'd3; end
    if (hit) begin
      m_mode = 0; m_cause = c; m_thold = -1;
    end else if (m_mode == 0) begin
      if (!deb_pre) m_mode = 1;
    end else if (m_mode == 1) begin
      if (lock_pre) begin m_mode = 2; m_thold = m_n; end
    end
    lq.push_back(pll_locked); lq.delete(0);
    bq.push_back(btn);        bq.delete(0);
    m_rose = 1'b0;
    if (bsync_pre != m_deb) begin
      m_run++;
      if (m_run == DEB) begin m_deb = bsync_pre; m_run = 0; m_rose = m_deb; end
    end else begin
      m_run = 0;
    end
  endfunction

  function automatic logic [NCH-1:0] exp_rst();
    logic [NCH-1:0] r;
    r = {NCH{1'b1}};
    if (m_mode == 2)
      for (int i = 0; i < NCH; i++)
        r[i] = ((m_n - m_thold) >= HOLD + i * STAG) ? 1'b0 : 1'b1;
    return r;
  endfunction

  function automatic logic exp_ready();
    return (m_mode == 2) && ((m_n - m_thold) >= HOLD + (NCH - 1) * STAG + 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rst"},   32'(rst_out), 32'(exp_rst()));
    check({tag, "_ready"}, 32'(ready),   32'(exp_ready()));
    check({tag, "_cause"}, 32'(cause),   32'(m_cause));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_async_rst"},   32'(rst_out), 32'h7);
    check({tag, "_async_cause"}, 32'(cause),   32'h0);
    check({tag, "_async_ready"}, 32'(ready),   32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic por_seq(input string tag);
    for (int e = 1; e <= 22; e++) begin
      tick(tag);
      if (e == 10) check({tag, "_e10"}, 32'(rst_out), 32'h7);
      else if (e == 11) check({tag, "_e11"}, 32'(rst_out), 32'h6);
      else if (e == 14) check({tag, "_e14"}, 32'(rst_out), 32'h6);
      else if (e == 15) check({tag, "_e15"}, 32'(rst_out), 32'h4);
      else if (e == 19) begin
        check({tag, "_e19"}, 32'(rst_out), 32'h0);
        check({tag, "_e19_ready"}, 32'(ready), 32'h0);
      end else if (e == 20) begin
        check({tag, "_e20_ready"}, 32'(ready), 32'h1);
        check({tag, "_e20_cause"}, 32'(cause), 32'h0);
      end
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < budget) begin tick(tag); k++; end
    check({tag, "_ready_wait"}, 32'(ready), 32'h1);
  endtask

  task automatic wait_rst(input logic [NCH-1:0] val, input string tag, input int budget);
    int k;
    k = 0;
    while (rst_out !== val && k < budget) begin tick(tag); k++; end
    check({tag, "_rst_wait"}, 32'(rst_out), 32'(val));
  endtask

  initial begin
    int r, press_left;

    do_reset("por");
    por_seq("por");

    // lock loss in RUN for 5 cycles
    pll_locked = 1'b0;
    tick("lock"); tick("lock");
    check("lock_e2", 32'(rst_out), 32'h0);
    tick("lock");
    check("lock_e3_rst", 32'(rst_out), 32'h7);
    check("lock_e3_cause", 32'(cause), 32'h1);
    tick("lock"); tick("lock");
    pll_locked = 1'b1;
    wait_ready("lock_recover", 60);

    // short button bounces are ignored
    repeat (3) begin
      btn = 1'b1; repeat (4) tick("bounce");
      btn = 1'b0; repeat (4) tick("bounce");
    end
    repeat (20) tick("bounce");
    check("bounce_rst", 32'(rst_out), 32'h0);
    check("bounce_ready", 32'(ready), 32'h1);

    // stable press resets and holds ASSERT until released
    btn = 1'b1;
    repeat (20) tick("press");
    check("press_rst", 32'(rst_out), 32'h7);
    check("press_cause", 32'(cause), 32'h2);
    repeat (10) tick("press_hold");
    check("press_hold_ready", 32'(ready), 32'h0);
    btn = 1'b0;
    wait_rst(3'b110, "btn_release", 80);

    // software request in RELEASE
    sw_rst_req = 1'b1; tick("sw_rel"); sw_rst_req = 1'b0;
    check("sw_rel_rst", 32'(rst_out), 32'h7);
    check("sw_rel_cause", 32'(cause), 32'h3);
    wait_ready("sw_recover", 60);

    // lock loss and software request reach the FSM on the same edge
    pll_locked = 1'b0;
    tick("simul"); tick("simul");
    sw_rst_req = 1'b1; tick("simul"); sw_rst_req = 1'b0;
    check("simul_cause", 32'(cause), 32'h1);
    check("simul_rst", 32'(rst_out), 32'h7);
    pll_locked = 1'b1;
    sw_rst_req = 1'b1; tick("sw_in_assert"); sw_rst_req = 1'b0;
    check("sw_in_assert_cause", 32'(cause), 32'h1);
    wait_ready("simul_recover", 60);

    // reset_n mid-HOLD
    sw_rst_req = 1'b1; tick("to_hold"); sw_rst_req = 1'b0;
    repeat (4) tick("to_hold");
    do_reset("hold");
    por_seq("hold_por");

    // reset_n mid-RELEASE
    sw_rst_req = 1'b1; tick("to_rel"); sw_rst_req = 1'b0;
    wait_rst(3'b110, "to_rel", 40);
    tick("to_rel");
    do_reset("rel");
    por_seq("rel_por");

    // randomized traffic against the model
    press_left = 0;
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 999);
      sw_rst_req = (r < 15) ? 1'b1 : 1'b0;
      pll_locked = (r >= 15 && r < 20) ? 1'b0 : 1'b1;
      if (press_left > 0) begin
        btn = 1'b1; press_left--;
      end else if (r >= 20 && r < 24) begin
        btn = 1'b1; press_left = $urandom_range(18, 30);
      end else begin
        btn = (r >= 24 && r < 40) ? 1'b1 : 1'b0;
      end
      tick("rand");
    end
    sw_rst_req = 1'b0; pll_locked = 1'b1; btn = 1'b0;
    wait_ready("final", 120);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
